div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter SIZE, default 64, sets the operand/result width in bits.
REQ-002 Parameter TAG_W, default 5, sets the requester tag width (destination register number).
REQ-003 Parameter TIMEOUT, default SIZE+8, sets the maximum cycles spent in WAIT before abort.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
REQ-006 reqN_valid / reqN_ready  in/out  1 each, N=0,1  per-port request handshake.
REQ-007 reqN_signed  in  1  1 selects SDIV, 0 selects UDIV.
REQ-008 reqN_dividend, reqN_divisor  in  SIZE each  operands.
REQ-009 reqN_tag  in  TAG_W  opaque tag returned with the result.
REQ-010 rsp_valid / rsp_ready  out/in  1 each  result handshake.
REQ-011 rsp_port  out  1  index of the port that issued the request.
REQ-012 rsp_tag  out  TAG_W  tag captured at acceptance.
REQ-013 rsp_quotient, rsp_remainder  out  SIZE each  results.
REQ-014 rsp_div_zero, rsp_timeout  out  1 each  status flags.
REQ-015 div_start  out  1  one-cycle start pulse to the iterative divider.
REQ-016 div_is_signed, div_dividend, div_divisor  out  1/SIZE/SIZE  divider operands; held stable from START through WAIT.
REQ-017 div_quotient, div_remainder, div_done  in  SIZE/SIZE/1  divider results; div_done is a one-cycle pulse.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, START, WAIT and RESP.
REQ-020 In IDLE, reqN_ready SHALL be 1 only for the granted port; it SHALL be 0 in every other state.
REQ-021 Acceptance SHALL occur on a clock edge with reqN_valid and reqN_ready both high.
- On acceptance, the block SHALL latch the operands, signed bit, tag and port index.
REQ-022 Arbitration:
- With one port valid, that port SHALL be granted.
- With both ports valid, the port named by the round-robin pointer SHALL be granted.
- After each acceptance, the pointer SHALL point to the other port.
REQ-023 Fast path, divide by zero: a divisor of 0 SHALL give quotient=0, remainder=dividend and rsp_div_zero=1.
- The block SHALL go directly to RESP without pulsing div_start.
REQ-024 Fast path, signed overflow: signed, dividend=1<<(SIZE-1) and divisor=all-ones SHALL give quotient=dividend and remainder=0.
- The block SHALL go directly to RESP without pulsing div_start.
REQ-025 Otherwise, IDLE SHALL go to START, and START SHALL drive div_start=1 for exactly one cycle, then go to WAIT.
REQ-026 WAIT exit:
- div_done=1 SHALL capture div_quotient/div_remainder into the response registers and go to RESP.
- After TIMEOUT cycles in WAIT without div_done, the block SHALL go to RESP with rsp_timeout=1 and quotient=remainder=0.
REQ-027 In RESP, rsp_valid SHALL be 1 and the rsp_* outputs SHALL be stable.
- rsp_valid&&rsp_ready SHALL return the FSM to IDLE; no new request SHALL be accepted in that same cycle.
REQ-028 A div_done arriving outside WAIT SHALL be ignored.
REQ-029 Latency, fast path: rsp_valid SHALL assert on the cycle after acceptance.
REQ-030 Latency, divider path: rsp_valid SHALL assert on the cycle after div_done.
REQ-031 The WAIT cycle counter SHALL be ceil(log2(TIMEOUT+1)) bits wide, SHALL clear on entry to START, and SHALL saturate.

Reset
REQ-032 While reset=0, the block SHALL hold: state=IDLE, pointer=port 0, and all outputs 0 (rsp_*, div_*, reqN_ready, busy).
REQ-033 Reset asserted mid-operation SHALL discard the in-flight request without a response and SHALL NOT pulse div_start.
REQ-034 After reset deasserts, the first grant with both ports valid SHALL go to port 0.

Verification
REQ-035 Port 0 UDIV 100/7, tag 3, divider model with SIZE+1 cycle latency -> rsp quotient=14, remainder=2, port=0, tag=3, div_zero=0.
REQ-036 Both ports valid with back-to-back requests (p0: 9/3, p1: 8/2), rsp_ready=1 -> grants in order p0, p1, p0; responses match each port and tag.
REQ-037 Port 1 SDIV -7/0 -> rsp_valid on the cycle after acceptance, quotient=0, remainder=-7, div_zero=1, no div_start pulse.
REQ-038 SDIV MIN/-1 -> quotient=MIN, remainder=0, no div_start pulse.
REQ-039 Divider model never asserts div_done -> rsp_timeout=1 exactly TIMEOUT cycles after entering WAIT; hold rsp_ready=0 for 5 cycles -> outputs stable; then release -> return to IDLE.
REQ-040 Assert reset during WAIT -> busy=0, rsp_valid=0 and pointer=0 immediately; a later stray div_done produces no response.

Source files
------------

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// DivArbiter (module div_arbiter)
// Two-port front end for a shared iterative divider. One request is accepted
// at a time, chosen round-robin when both ports are valid. Divide-by-zero and
// signed MIN/-1 are answered directly without using the divider. A watchdog
// ends a divide that never reports done with a timeout response.
//
// Ports
//   clk, reset            clock (rising edge) and async active-low reset
//   reqN_*  (N=0,1)       valid/ready handshake, signed select, operands, tag
//   rsp_*                 valid/ready handshake, issuing port, tag, results,
//                         div-by-zero and timeout flags
//   div_*                 start pulse and held operands out to the divider,
//                         quotient/remainder/done pulse back from it
//   busy                  high whenever a request is in flight
// ---------------------------------------------------------------------------
module div_arbiter #(
   parameter int SIZE    = 64,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = SIZE + 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic             req0_signed,
   input  logic [SIZE-1:0]  req0_dividend,
   input  logic [SIZE-1:0]  req0_divisor,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic             req1_signed,
   input  logic [SIZE-1:0]  req1_dividend,
   input  logic [SIZE-1:0]  req1_divisor,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_port,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [SIZE-1:0]  rsp_quotient,
   output logic [SIZE-1:0]  rsp_remainder,
   output logic             rsp_div_zero,
   output logic             rsp_timeout,
   output logic             div_start,
   output logic             div_is_signed,
   output logic [SIZE-1:0]  div_dividend,
   output logic [SIZE-1:0]  div_divisor,
   input  logic [SIZE-1:0]  div_quotient,
   input  logic [SIZE-1:0]  div_remainder,
   input  logic             div_done,
   output logic             busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [SIZE-1:0] MIN_VAL = {1'b1, {(SIZE-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_ptr;
   logic [CNT_W-1:0]   r_waitCnt;
   logic               r_signed;
   logic [SIZE-1:0]    r_dividend;
   logic [SIZE-1:0]    r_divisor;
   logic               r_port;
   logic [TAG_W-1:0]   r_tag;
   logic [SIZE-1:0]    r_quotient;
   logic [SIZE-1:0]    r_remainder;
   logic               r_divZero;
   logic               r_timeout;

   logic               w_grant;
   logic               w_idleLive;
   logic               w_accept;
   logic               w_selSigned;
   logic [SIZE-1:0]    w_selDividend;
   logic [SIZE-1:0]    w_selDivisor;
   logic [TAG_W-1:0]   w_selTag;
   logic               w_divZero;
   logic               w_overflow;
   logic               w_timeoutHit;

   // A lone valid port wins outright; a tie goes to the round-robin pointer.
   // Ready is also gated by reset so nothing handshakes while reset is held.
   assign w_grant    = (req1_valid && !req0_valid) ? 1'b1 :
                       (req0_valid && !req1_valid) ? 1'b0 : r_ptr;
   assign w_idleLive = (r_state == IDLE) && reset;
   assign req0_ready = w_idleLive && !w_grant;
   assign req1_ready = w_idleLive && w_grant;
   assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   assign w_selSigned   = w_grant ? req1_signed   : req0_signed;
   assign w_selDividend = w_grant ? req1_dividend : req0_dividend;
   assign w_selDivisor  = w_grant ? req1_divisor  : req0_divisor;
   assign w_selTag      = w_grant ? req1_tag      : req0_tag;

   // Cases the divider must not see: they are answered straight from IDLE.
   assign w_divZero  = (w_selDivisor == '0);
   assign w_overflow = w_selSigned && (w_selDividend == MIN_VAL) && (w_selDivisor == '1);

   // The counter holds the number of WAIT cycles already spent, so the last
   // permitted WAIT cycle is the one where it reads TIMEOUT-1.
   assign w_timeoutHit = (r_waitCnt >= CNT_W'(TIMEOUT - 1));

   assign rsp_valid     = (r_state == RESP);
   assign div_start     = (r_state == START);
   assign busy          = (r_state != IDLE);
   assign rsp_port      = r_port;
   assign rsp_tag       = r_tag;
   assign rsp_quotient  = r_quotient;
   assign rsp_remainder = r_remainder;
   assign rsp_div_zero  = r_divZero;
   assign rsp_timeout   = r_timeout;
   assign div_is_signed = r_signed;
   assign div_dividend  = r_dividend;
   assign div_divisor   = r_divisor;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic. Leaving RESP always lands in IDLE, so a request cannot
   // be accepted on the same edge that completes a response.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (w_accept) w_next = (w_divZero || w_overflow) ? RESP : START;
         START: w_next = WAIT;
         WAIT:  if (div_done || w_timeoutHit) w_next = RESP;
         RESP:  if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: capture the request on acceptance, fill in the result from the
   // fast path, the divider or the watchdog, and hold it steady through RESP.
   // div_done is only looked at in WAIT, so stray pulses elsewhere are dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr       <= 1'b0;
         r_waitCnt   <= '0;
         r_signed    <= 1'b0;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_port      <= 1'b0;
         r_tag       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_divZero   <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_ptr      <= ~w_grant;
                  r_port     <= w_grant;
                  r_signed   <= w_selSigned;
                  r_dividend <= w_selDividend;
                  r_divisor  <= w_selDivisor;
                  r_tag      <= w_selTag;
                  r_divZero  <= w_divZero;
                  r_timeout  <= 1'b0;
                  r_waitCnt  <= '0;
                  if (w_divZero) begin
                     r_quotient  <= '0;
                     r_remainder <= w_selDividend;
                  end else if (w_overflow) begin
                     r_quotient  <= w_selDividend;
                     r_remainder <= '0;
                  end else begin
                     r_quotient  <= '0;
                     r_remainder <= '0;
                  end
               end
            end
            WAIT: begin
               if (div_done) begin
                  r_quotient  <= div_quotient;
                  r_remainder <= div_remainder;
               end else if (w_timeoutHit) begin
                  r_quotient  <= '0;
                  r_remainder <= '0;
                  r_timeout   <= 1'b1;
               end
               if (r_waitCnt != CNT_W'(TIMEOUT)) begin
                  r_waitCnt <= r_waitCnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter
// Directed bench for div_arbiter at default parameters (SIZE=64, TIMEOUT=72).
// A behavioural divider answers each div_start after SIZE+1 cycles unless it
// is switched off; a separate stray pulse source drives extra div_done pulses.
// ---------------------------------------------------------------------------
module tb_div_arbiter;

   localparam int SIZE    = 64;
   localparam int TAG_W   = 5;
   localparam int TIMEOUT = SIZE + 8;
   localparam logic [SIZE-1:0] MIN_VAL = {1'b1, {(SIZE-1){1'b0}}};

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req0_ready, req0_signed;
   logic [SIZE-1:0]  req0_dividend, req0_divisor;
   logic [TAG_W-1:0] req0_tag;
   logic             req1_valid, req1_ready, req1_signed;
   logic [SIZE-1:0]  req1_dividend, req1_divisor;
   logic [TAG_W-1:0] req1_tag;
   logic             rsp_valid, rsp_ready, rsp_port;
   logic [TAG_W-1:0] rsp_tag;
   logic [SIZE-1:0]  rsp_quotient, rsp_remainder;
   logic             rsp_div_zero, rsp_timeout;
   logic             div_start, div_is_signed;
   logic [SIZE-1:0]  div_dividend, div_divisor;
   logic [SIZE-1:0]  div_quotient, div_remainder;
   logic             div_done;
   logic             busy;

   logic             mdlDone = 1'b0;
   logic             strayDone = 1'b0;
   logic             modelOn = 1'b1;
   logic [SIZE-1:0]  mdlQ = '0;
   logic [SIZE-1:0]  mdlR = '0;
   int               startCount = 0;

   int               nTests = 0;
   int               nFail = 0;

   assign div_done      = mdlDone | strayDone;
   assign div_quotient  = mdlQ;
   assign div_remainder = mdlR;

   always #5 clk = ~clk;

   div_arbiter #(.SIZE(SIZE), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_signed(req0_signed),
      .req0_dividend(req0_dividend), .req0_divisor(req0_divisor), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_signed(req1_signed),
      .req1_dividend(req1_dividend), .req1_divisor(req1_divisor), .req1_tag(req1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port), .rsp_tag(rsp_tag),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
      .rsp_div_zero(rsp_div_zero), .rsp_timeout(rsp_timeout),
      .div_start(div_start), .div_is_signed(div_is_signed),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
      .busy(busy)
   );

   // Behavioural divider: counts every start pulse, and when enabled returns
   // the quotient/remainder with a one-cycle done pulse SIZE+1 cycles later.
   initial begin
      logic [SIZE-1:0] a, b;
      logic            s;
      forever begin
         @(negedge clk);
         if (div_start) startCount++;
         if (div_start && modelOn) begin
            a = div_dividend;
            b = div_divisor;
            s = div_is_signed;
            repeat (SIZE + 1) @(negedge clk);
            mdlQ = s ? SIZE'($signed(a) / $signed(b)) : a / b;
            mdlR = s ? SIZE'($signed(a) % $signed(b)) : a % b;
            mdlDone = 1'b1;
            @(negedge clk);
            mdlDone = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
      nTests++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit port, input bit sgn, input logic [SIZE-1:0] dvd,
                                input logic [SIZE-1:0] dvs, input logic [TAG_W-1:0] tag);
      if (port) begin
         req1_valid = 1'b1; req1_signed = sgn; req1_dividend = dvd;
         req1_divisor = dvs; req1_tag = tag;
      end else begin
         req0_valid = 1'b1; req0_signed = sgn; req0_dividend = dvd;
         req0_divisor = dvs; req0_tag = tag;
      end
   endtask

   // Waits (bounded) for rsp_valid, returning the number of negedges waited.
   task automatic waitResp(output int cycles);
      cycles = 0;
      while (!rsp_valid && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("resp_arrived", 64'(rsp_valid), 64'd1);
   endtask

   initial begin
      int cyc;
      int s0;
      reset = 1'b0;
      rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_signed = 1'b0; req0_dividend = '0; req0_divisor = '0; req0_tag = '0;
      req1_valid = 1'b0; req1_signed = 1'b0; req1_dividend = '0; req1_divisor = '0; req1_tag = '0;

      // Both ports contend from reset: p0 9/3 tag 1, p1 8/2 tag 2.
      applyStimulus(1'b0, 1'b0, 64'd9, 64'd3, 5'd1);
      applyStimulus(1'b1, 1'b0, 64'd8, 64'd2, 5'd2);
      @(negedge clk);
      checkOutput("rst_ready0", 64'(req0_ready), 64'd0);
      checkOutput("rst_ready1", 64'(req1_ready), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_div_start", 64'(div_start), 64'd0);
      checkOutput("rst_quotient", rsp_quotient, 64'd0);

      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("first_grant_ready0", 64'(req0_ready), 64'd1);
      checkOutput("first_grant_ready1", 64'(req1_ready), 64'd0);

      waitResp(cyc);
      checkOutput("rr1_port", 64'(rsp_port), 64'd0);
      checkOutput("rr1_tag", 64'(rsp_tag), 64'd1);
      checkOutput("rr1_quot", rsp_quotient, 64'd3);
      checkOutput("rr1_rem", rsp_remainder, 64'd0);
      checkOutput("resp_no_ready", 64'(req0_ready | req1_ready), 64'd0);
      @(negedge clk);
      checkOutput("rr2_ready1", 64'(req1_ready), 64'd1);
      checkOutput("rr2_ready0", 64'(req0_ready), 64'd0);
      waitResp(cyc);
      checkOutput("rr2_port", 64'(rsp_port), 64'd1);
      checkOutput("rr2_tag", 64'(rsp_tag), 64'd2);
      checkOutput("rr2_quot", rsp_quotient, 64'd4);
      checkOutput("rr2_rem", rsp_remainder, 64'd0);
      @(negedge clk);
      checkOutput("rr3_ready0", 64'(req0_ready), 64'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      waitResp(cyc);
      checkOutput("rr3_port", 64'(rsp_port), 64'd0);
      checkOutput("rr3_tag", 64'(rsp_tag), 64'd1);
      checkOutput("rr3_quot", rsp_quotient, 64'd3);
      @(negedge clk);

      // Port 0 UDIV 100/7 tag 3 through the divider.
      applyStimulus(1'b0, 1'b0, 64'd100, 64'd7, 5'd3);
      @(negedge clk);
      checkOutput("udiv_start", 64'(div_start), 64'd1);
      req0_valid = 1'b0;
      waitResp(cyc);
      checkOutput("div_latency", 64'(cyc), 64'(SIZE + 2));
      checkOutput("udiv_quot", rsp_quotient, 64'd14);
      checkOutput("udiv_rem", rsp_remainder, 64'd2);
      checkOutput("udiv_port", 64'(rsp_port), 64'd0);
      checkOutput("udiv_tag", 64'(rsp_tag), 64'd3);
      checkOutput("udiv_dz", 64'(rsp_div_zero), 64'd0);
      checkOutput("udiv_to", 64'(rsp_timeout), 64'd0);
      @(negedge clk);

      // Port 1 SDIV -7/0 tag 5: fast path.
      s0 = startCount;
      applyStimulus(1'b1, 1'b1, -64'sd7, 64'd0, 5'd5);
      @(negedge clk);
      checkOutput("dz_latency", 64'(rsp_valid), 64'd1);
      req1_valid = 1'b0;
      checkOutput("dz_quot", rsp_quotient, 64'd0);
      checkOutput("dz_rem", rsp_remainder, 64'hFFFF_FFFF_FFFF_FFF9);
      checkOutput("dz_flag", 64'(rsp_div_zero), 64'd1);
      checkOutput("dz_port", 64'(rsp_port), 64'd1);
      checkOutput("dz_tag", 64'(rsp_tag), 64'd5);
      checkOutput("dz_no_start", 64'(startCount), 64'(s0));
      @(negedge clk);

      // Port 0 SDIV MIN/-1 tag 7: fast path.
      applyStimulus(1'b0, 1'b1, MIN_VAL, '1, 5'd7);
      @(negedge clk);
      checkOutput("ovf_latency", 64'(rsp_valid), 64'd1);
      req0_valid = 1'b0;
      checkOutput("ovf_quot", rsp_quotient, 64'h8000_0000_0000_0000);
      checkOutput("ovf_rem", rsp_remainder, 64'd0);
      checkOutput("ovf_dz", 64'(rsp_div_zero), 64'd0);
      checkOutput("ovf_no_start", 64'(startCount), 64'(s0));
      @(negedge clk);

      // Divider silent: watchdog timeout, then hold the response for 5 cycles.
      modelOn = 1'b0;
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 64'd50, 64'd5, 5'd9);
      @(negedge clk);
      checkOutput("to_start", 64'(div_start), 64'd1);
      req0_valid = 1'b0;
      waitResp(cyc);
      checkOutput("to_latency", 64'(cyc), 64'(TIMEOUT + 1));
      checkOutput("to_flag", 64'(rsp_timeout), 64'd1);
      checkOutput("to_quot", rsp_quotient, 64'd0);
      checkOutput("to_rem", rsp_remainder, 64'd0);
      checkOutput("to_tag", 64'(rsp_tag), 64'd9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 64'(rsp_valid), 64'd1);
         checkOutput("hold_flag", 64'(rsp_timeout), 64'd1);
         checkOutput("hold_tag", 64'(rsp_tag), 64'd9);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("to_release_busy", 64'(busy), 64'd0);
      checkOutput("to_release_valid", 64'(rsp_valid), 64'd0);

      // Reset during WAIT, pointer currently at port 1.
      applyStimulus(1'b0, 1'b0, 64'd20, 64'd4, 5'd4);
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("pre_rst_busy", 64'(busy), 64'd1);
      s0 = startCount;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      reset = 1'b0;
      #1;
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_valid", 64'(rsp_valid), 64'd0);
      checkOutput("midrst_start", 64'(div_start), 64'd0);
      checkOutput("midrst_ready", 64'(req0_ready | req1_ready), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("ptr_rst_ready0", 64'(req0_ready), 64'd1);
      checkOutput("ptr_rst_ready1", 64'(req1_ready), 64'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      strayDone = 1'b1;
      @(negedge clk);
      strayDone = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("stray_valid", 64'(rsp_valid), 64'd0);
      checkOutput("stray_busy", 64'(busy), 64'd0);
      checkOutput("stray_no_start", 64'(startCount), 64'(s0));

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
